// File: rtl/ex_operand_pkg.sv
// Shared definitions for the ID/EX operand stage: control-bit layout,
// forward-select encoding and the ID/EX pipeline register record.
package ex_operand_pkg;

    localparam int ALU_OP_W = 6;
    localparam int ID_CTRL_W = 7;
    localparam int EX_CTRL_W = 4;

    // Bit positions inside id_ctrl
    localparam int CTRL_USE_RS     = 6;
    localparam int CTRL_USE_RT     = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    // Bit positions inside ex_ctrl (the low four id_ctrl bits, same order)
    localparam int EX_REG_WRITE  = 3;
    localparam int EX_MEM_READ   = 2;
    localparam int EX_MEM_WRITE  = 1;
    localparam int EX_MEM_TO_REG = 0;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           rs;
        logic [4:0]           rt;
        logic [4:0]           waddr;
        logic [31:0]          rs_data;
        logic [31:0]          rt_data;
        logic [31:0]          imm;
        logic [ALU_OP_W-1:0]  alu_ctrl;
        logic                 alu_src;
        logic [EX_CTRL_W-1:0] ctrl;
    } id_ex_t;

    // EX/MEM wins over WB; register 0 is hard-wired and never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] src_addr,
        input logic       mem_we,
        input logic [4:0] mem_addr,
        input logic       wb_we,
        input logic [4:0] wb_addr
    );
        if (mem_we && (mem_addr != 5'd0) && (mem_addr == src_addr))
            return FWD_MEM;
        else if (wb_we && (wb_addr != 5'd0) && (wb_addr == src_addr))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand forwarding: picks EX/MEM result, WB data or the latched value.
module fwd_mux
    import ex_operand_pkg::*;
(
    input  logic [4:0]  src_addr,
    input  logic [31:0] src_data,
    input  logic        mem_we,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] out_data
);

    fwd_sel_e sel;

    // Select the youngest producer of src_addr and steer its data out
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        out_data = src_data;
        sel      = fwd_select(src_addr, mem_we, mem_addr, wb_we, wb_addr);
        case (sel)
            FWD_MEM: out_data = mem_data;
            FWD_WB:  out_data = wb_data;
            default: out_data = src_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use stall detection, WB write-through
// at capture, and EX-stage operand forwarding.
module ex_operand_stage
    import ex_operand_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [4:0]            id_rs,
    input  logic [4:0]            id_rt,
    input  logic [4:0]            id_waddr,
    input  logic [31:0]           id_rs_data,
    input  logic [31:0]           id_rt_data,
    input  logic [31:0]           id_imm,
    input  logic [ALU_OP_W-1:0]   id_alu_ctrl,
    input  logic [ID_CTRL_W-1:0]  id_ctrl,
    input  logic                  flush,
    input  logic                  mem_fwd_we,
    input  logic [4:0]            mem_fwd_addr,
    input  logic [31:0]           mem_fwd_data,
    input  logic                  wb_we,
    input  logic [4:0]            wb_addr,
    input  logic [31:0]           wb_data,
    output logic                  stall_id,
    output logic                  ex_valid,
    output logic [31:0]           ex_a,
    output logic [31:0]           ex_b,
    output logic [4:0]            ex_sa,
    output logic [ALU_OP_W-1:0]   ex_alu_ctrl,
    output logic [31:0]           ex_store_data,
    output logic [4:0]            ex_waddr,
    output logic [EX_CTRL_W-1:0]  ex_ctrl
);

    id_ex_t      id_ex_q, id_ex_d;
    logic        load_use;
    logic        bubble;
    logic [31:0] fwd_rt;

    // Load-use hazard: a load in EX whose destination is a source needed in ID
    always_comb begin
        load_use = id_ex_q.valid && id_ex_q.ctrl[EX_MEM_READ] && (id_ex_q.waddr != 5'd0) &&
                   ((id_ctrl[CTRL_USE_RS] && (id_rs == id_ex_q.waddr)) ||
                    (id_ctrl[CTRL_USE_RT] && (id_rt == id_ex_q.waddr)));
        stall_id = load_use && id_valid && !flush;
        bubble   = flush || stall_id || !id_valid;
    end

    // Next ID/EX contents: all-zero bubble, or ID fields with WB write-through
    always_comb begin
        id_ex_d = '0;
        if (!bubble) begin
            id_ex_d.valid    = 1'b1;
            id_ex_d.rs       = id_rs;
            id_ex_d.rt       = id_rt;
            id_ex_d.waddr    = id_waddr;
            id_ex_d.imm      = id_imm;
            id_ex_d.alu_ctrl = id_alu_ctrl;
            id_ex_d.alu_src  = id_ctrl[CTRL_ALU_SRC];
            id_ex_d.ctrl     = id_ctrl[CTRL_REG_WRITE:CTRL_MEM_TO_REG];
            id_ex_d.rs_data  = (wb_we && (wb_addr != 5'd0) && (wb_addr == id_rs)) ? wb_data : id_rs_data;
            id_ex_d.rt_data  = (wb_we && (wb_addr != 5'd0) && (wb_addr == id_rt)) ? wb_data : id_rt_data;
        end
    end

    // ID/EX register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
        if (rst)
            id_ex_q <= '0;
        else
            id_ex_q <= id_ex_d;
    end

    fwd_mux u_fwd_rs (
        .src_addr (id_ex_q.rs),
        .src_data (id_ex_q.rs_data),
        .mem_we   (mem_fwd_we),
        .mem_addr (mem_fwd_addr),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .out_data (ex_a)
    );

    fwd_mux u_fwd_rt (
        .src_addr (id_ex_q.rt),
        .src_data (id_ex_q.rt_data),
        .mem_we   (mem_fwd_we),
        .mem_addr (mem_fwd_addr),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .out_data (fwd_rt)
    );

    assign ex_valid      = id_ex_q.valid;
    assign ex_b          = id_ex_q.alu_src ? id_ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_sa         = id_ex_q.imm[10:6];
    assign ex_alu_ctrl   = id_ex_q.alu_ctrl;
    assign ex_waddr      = id_ex_q.waddr;
    assign ex_ctrl       = id_ex_q.ctrl;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table plus hazard sequences.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_waddr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [5:0]  id_alu_ctrl;
    logic [6:0]  id_ctrl;
    logic        flush;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_addr;
    logic [31:0] mem_fwd_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_id, ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_sa, ex_waddr;
    logic [5:0]  ex_alu_ctrl;
    logic [3:0]  ex_ctrl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_waddr(id_waddr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl), .id_ctrl(id_ctrl), .flush(flush),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_sa(ex_sa),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_waddr(ex_waddr),
        .ex_ctrl(ex_ctrl)
    );

    // id_ctrl = {use_rs, use_rt, alu_src, reg_write, mem_read, mem_write, mem_to_reg}
    localparam logic [6:0] C_RTYPE = 7'h68;  // use_rs, use_rt, reg_write
    localparam logic [6:0] C_STORE = 7'h72;  // use_rs, use_rt, alu_src, mem_write
    localparam logic [6:0] C_LOAD  = 7'h5D;  // use_rs, alu_src, reg_write, mem_read, mem_to_reg

    typedef struct {
        logic        valid;
        logic        flush;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  waddr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [5:0]  alu;
        logic [6:0]  ctrl;
        logic        cwb_we;     // WB port during capture cycle
        logic [4:0]  cwb_addr;
        logic [31:0] cwb_data;
        logic        mem_we;     // forwarding sources during EX cycle
        logic [4:0]  mem_addr;
        logic [31:0] mem_data;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        chk_data;   // compare operands (instruction not a bubble)
        logic        e_valid;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [4:0]  e_sa;
        logic [31:0] e_store;
        logic [4:0]  e_waddr;
        logic [3:0]  e_ctrl;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] wa, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [5:0] alu, input logic [6:0] ctl);
        id_valid = v; id_rs = rs; id_rt = rt; id_waddr = wa;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_ctrl = alu; id_ctrl = ctl;
    endtask

    task automatic fwd_off();
        mem_fwd_we = 1'b0; mem_fwd_addr = 5'd0; mem_fwd_data = 32'h0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            vld flu rs rt wa  rs_data       rt_data       imm            alu    ctrl     cwb(we,addr,data)   mem(we,addr,data)     wb(we,addr,data)       chk ev  e_a           e_b            sa     e_store       wa     ctrl
        vecs[0]  = '{1'b1,1'b0,5'd1,5'd2,5'd3, 32'h11,      32'h22,      32'h140,      6'h20, C_RTYPE, 1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,       1'b1,1'b1,32'h11,      32'h22,        5'd5,  32'h22,       5'd3,  4'h8};
        vecs[1]  = '{1'b1,1'b0,5'd5,5'd6,5'd7, 32'h1,       32'h66,      32'h0,        6'h21, C_RTYPE, 1'b0,5'd0,32'h0,     1'b1,5'd5,32'h10,     1'b1,5'd5,32'h20,      1'b1,1'b1,32'h10,      32'h66,        5'd0,  32'h66,       5'd7,  4'h8};
        vecs[2]  = '{1'b1,1'b0,5'd1,5'd9,5'd10,32'hA,       32'hB,       32'h0,        6'h22, C_RTYPE, 1'b0,5'd0,32'h0,     1'b1,5'd4,32'h44,     1'b1,5'd9,32'h99,      1'b1,1'b1,32'hA,       32'h99,        5'd0,  32'h99,       5'd10, 4'h8};
        vecs[3]  = '{1'b1,1'b0,5'd0,5'd0,5'd11,32'h0,       32'h0,       32'h0,        6'h20, C_RTYPE, 1'b0,5'd0,32'h0,     1'b1,5'd0,32'hDEAD,   1'b1,5'd0,32'hBEEF,    1'b1,1'b1,32'h0,       32'h0,         5'd0,  32'h0,        5'd11, 4'h8};
        vecs[4]  = '{1'b1,1'b0,5'd7,5'd8,5'd12,32'h0,       32'h88,      32'h0,        6'h20, C_RTYPE, 1'b1,5'd7,32'h1234,  1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,       1'b1,1'b1,32'h1234,    32'h88,        5'd0,  32'h88,       5'd12, 4'h8};
        vecs[5]  = '{1'b1,1'b0,5'd2,5'd3,5'd0, 32'h1000,    32'h3333,    32'hFFFFFFFC, 6'h2B, C_STORE, 1'b0,5'd0,32'h0,     1'b1,5'd3,32'h5555,   1'b0,5'd0,32'h0,       1'b1,1'b1,32'h1000,    32'hFFFFFFFC,  5'd31, 32'h5555,     5'd0,  4'h2};
        vecs[6]  = '{1'b0,1'b0,5'd1,5'd2,5'd13,32'h5,       32'h6,       32'h0,        6'h20, C_RTYPE, 1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,       1'b0,1'b0,32'h0,       32'h0,         5'd0,  32'h0,        5'd0,  4'h0};
        vecs[7]  = '{1'b1,1'b1,5'd1,5'd2,5'd13,32'h5,       32'h6,       32'h0,        6'h20, C_RTYPE, 1'b0,5'd0,32'h0,     1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,       1'b0,1'b0,32'h0,       32'h0,         5'd0,  32'h0,        5'd0,  4'h0};
        vecs[8]  = '{1'b1,1'b0,5'd6,5'd6,5'd14,32'h1,       32'h2,       32'h0,        6'h20, C_RTYPE, 1'b0,5'd0,32'h0,     1'b1,5'd6,32'h60,     1'b1,5'd6,32'h70,      1'b1,1'b1,32'h60,      32'h60,        5'd0,  32'h60,       5'd14, 4'h8};
        vecs[9]  = '{1'b1,1'b0,5'd4,5'd4,5'd15,32'h4,       32'h5,       32'h0,        6'h20, C_RTYPE, 1'b0,5'd4,32'hFF,    1'b0,5'd4,32'hEE,     1'b0,5'd4,32'hFF,      1'b1,1'b1,32'h4,       32'h5,         5'd0,  32'h5,        5'd15, 4'h8};
        vecs[10] = '{1'b1,1'b0,5'd0,5'd3,5'd16,32'h0,       32'h3,       32'h0,        6'h20, C_RTYPE, 1'b1,5'd0,32'h77,    1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,       1'b1,1'b1,32'h0,       32'h3,         5'd0,  32'h3,        5'd16, 4'h8};

        // Reset with a valid instruction presented: register stays clear
        rst = 1'b1; flush = 1'b0;
        fwd_off();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h40, 6'h20, C_RTYPE);
        step(); step();
        check("rst ex_valid", {31'h0, ex_valid}, 32'h0);
        check("rst ex_ctrl", {28'h0, ex_ctrl}, 32'h0);
        check("rst ex_waddr", {27'h0, ex_waddr}, 32'h0);
        check("rst ex_alu_ctrl", {26'h0, ex_alu_ctrl}, 32'h0);
        check("rst ex_a", ex_a, 32'h0);
        check("rst stall_id", {31'h0, stall_id}, 32'h0);
        rst = 1'b0;

        // Table: capture cycle, then EX cycle with forwarding sources applied
        for (int i = 0; i < 11; i++) begin
            drive_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].waddr, vecs[i].rs_data,
                     vecs[i].rt_data, vecs[i].imm, vecs[i].alu, vecs[i].ctrl);
            flush = vecs[i].flush;
            mem_fwd_we = 1'b0; mem_fwd_addr = 5'd0; mem_fwd_data = 32'h0;
            wb_we = vecs[i].cwb_we; wb_addr = vecs[i].cwb_addr; wb_data = vecs[i].cwb_data;
            #1;
            check($sformatf("v%0d stall_id", i), {31'h0, stall_id}, 32'h0);
            step();
            mem_fwd_we = vecs[i].mem_we; mem_fwd_addr = vecs[i].mem_addr; mem_fwd_data = vecs[i].mem_data;
            wb_we = vecs[i].wb_we; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
            #1;
            check($sformatf("v%0d ex_valid", i), {31'h0, ex_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d ex_ctrl", i), {28'h0, ex_ctrl}, {28'h0, vecs[i].e_ctrl});
            check($sformatf("v%0d ex_waddr", i), {27'h0, ex_waddr}, {27'h0, vecs[i].e_waddr});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d ex_a", i), ex_a, vecs[i].e_a);
                check($sformatf("v%0d ex_b", i), ex_b, vecs[i].e_b);
                check($sformatf("v%0d ex_sa", i), {27'h0, ex_sa}, {27'h0, vecs[i].e_sa});
                check($sformatf("v%0d ex_store_data", i), ex_store_data, vecs[i].e_store);
                check($sformatf("v%0d ex_alu_ctrl", i), {26'h0, ex_alu_ctrl}, {26'h0, vecs[i].alu});
            end
        end
        flush = 1'b0;
        fwd_off();

        // Load-use: lw r3 in EX, dependent add in ID -> one stall, one bubble, WB forward
        drive_id(1'b1, 5'd1, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4, 6'h23, C_LOAD);
        step();
        drive_id(1'b1, 5'd1, 5'd3, 5'd4, 32'h100, 32'h0, 32'h0, 6'h20, C_RTYPE);
        #1;
        check("lu load ex_valid", {31'h0, ex_valid}, 32'h1);
        check("lu load ex_ctrl", {28'h0, ex_ctrl}, 32'hD);
        check("lu load ex_b imm", ex_b, 32'h4);
        check("lu stall_id high", {31'h0, stall_id}, 32'h1);
        step();
        check("lu bubble ex_valid", {31'h0, ex_valid}, 32'h0);
        check("lu bubble ex_ctrl", {28'h0, ex_ctrl}, 32'h0);
        check("lu stall_id released", {31'h0, stall_id}, 32'h0);
        step();
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hCAFE;
        #1;
        check("lu add ex_valid", {31'h0, ex_valid}, 32'h1);
        check("lu add ex_b from wb", ex_b, 32'hCAFE);
        check("lu add ex_store_data", ex_store_data, 32'hCAFE);
        check("lu add ex_a", ex_a, 32'h100);
        check("lu add ex_waddr", {27'h0, ex_waddr}, 32'h4);
        fwd_off();

        // Flush coincident with load-use: no stall, bubble next cycle
        drive_id(1'b1, 5'd1, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4, 6'h23, C_LOAD);
        step();
        drive_id(1'b1, 5'd3, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 6'h20, C_RTYPE);
        flush = 1'b1;
        #1;
        check("fl stall_id", {31'h0, stall_id}, 32'h0);
        step();
        check("fl ex_valid", {31'h0, ex_valid}, 32'h0);
        check("fl ex_ctrl", {28'h0, ex_ctrl}, 32'h0);
        check("fl ex_waddr", {27'h0, ex_waddr}, 32'h0);
        flush = 1'b0;

        // Reset mid-stream with a load in EX
        drive_id(1'b1, 5'd1, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4, 6'h23, C_LOAD);
        step();
        check("mr load ex_valid", {31'h0, ex_valid}, 32'h1);
        drive_id(1'b1, 5'd3, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 6'h20, C_RTYPE);
        rst = 1'b1;
        #1;
        check("mr stall before edge", {31'h0, stall_id}, 32'h1);
        step();
        check("mr ex_valid", {31'h0, ex_valid}, 32'h0);
        check("mr ex_ctrl", {28'h0, ex_ctrl}, 32'h0);
        check("mr ex_waddr", {27'h0, ex_waddr}, 32'h0);
        check("mr stall_id", {31'h0, stall_id}, 32'h0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
